hazard_unit: RTL

Pipeline hazard controller that produces the destination-register stage state consumed by the forwarding unit and generates the stall and bubble controls for the front of the pipe. It owns the EX/MEM and MEM/WB destination registers (rd, reg_write), detects load-use hazards between ID and EX, and holds EX for multi-cycle multiply operations. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers; its outputs drive the forwarding unit directly.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/mul_stall_fsm.sv | 63 ++++++
 rtl/hazard_unit.sv | 71 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, zero register, multiply FSM states
// and the destination-register payload carried through EX/MEM and MEM/WB.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned MUL_LATENCY_DEF = 4;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } dest_t;

endpackage

// File: rtl/mul_stall_fsm.sv
// Holds EX while a multi-cycle multiply occupies it; stall is combinational from state
// and the incoming multiply so the first occupancy cycle already stalls.
module mul_stall_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mul,
  input  logic flush,
  output logic stall
);

  localparam int unsigned CW = $clog2(MUL_LATENCY) + 1;
  localparam bit          MULTI_CYCLE = (MUL_LATENCY > 1);
  // Remaining stall cycles after the first one, loaded on entry to BUSY.
  localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

  mul_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (mul && !flush && MULTI_CYCLE) begin
          stall    = 1'b1;
          cnt_nx   = CNT_LOAD;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt != '0) begin
          stall  = 1'b1;
          cnt_nx = cnt - CW'(1);
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: load-use stall/bubble, EX/MEM and MEM/WB destination registers.
// Multiply EX hold is compiled in only when MULDIV_STALL_EN is defined.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  ID_EX_reg_write,
  input  logic                  ID_EX_mem_read,
  input  logic                  ID_EX_mul,
  input  logic                  flush_ex,
  output logic                  EX_MEM_reg_write,
  output logic [REG_ADDR_W-1:0] EX_MEM_rd,
  output logic                  MEM_WB_reg_write,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  bubble_id_ex
);

  dest_t ex_mem, mem_wb;
  logic  load_use;

`ifdef MULDIV_STALL_EN
  mul_stall_fsm #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_stall_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (ID_EX_mul),
    .flush (flush_ex),
    .stall (stall_ex)
  );
`else
  logic unused_mul;
  assign unused_mul = ID_EX_mul ^ (MUL_LATENCY == 0);
  assign stall_ex   = 1'b0;
`endif

  assign load_use = ID_EX_mem_read && (ID_EX_rd != REG_ZERO) &&
                    ((ID_EX_rd == IF_ID_rs) || (ID_EX_rd == IF_ID_rt));

  // A held ID/EX must not be overwritten by the load-use bubble.
  assign stall_id     = load_use | stall_ex;
  assign bubble_id_ex = load_use & ~stall_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (flush_ex || stall_ex) begin
        ex_mem <= '0;
      end else begin
        ex_mem <= '{reg_write: ID_EX_reg_write, rd: ID_EX_rd};
      end
      mem_wb <= ex_mem;
    end
  end

  assign EX_MEM_reg_write = ex_mem.reg_write;
  assign EX_MEM_rd        = ex_mem.rd;
  assign MEM_WB_reg_write = mem_wb.reg_write;
  assign MEM_WB_rd        = mem_wb.rd;

endmodule
